spi_master_ctrl: RTL

Byte-transfer sequencer for the SPI sender/receiver datapath. It accepts a host request and loads the TX byte into the sender. It then frames the transfer with chip-select, generates the bit clock for eight bit periods, captures the received byte from the receiver and reports completion. It sits between the host logic and the SENDER/RECEIVER pair; it owns every WRITE/TE/READ/RE strobe and the datapath clear.

---
 rtl/spi_master_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: sequences one SPI byte transfer.
// The sequence is: load the sender, frame it with CS_N, run 8 bit-clock periods,
// capture the received byte, then report DONE (and ERR).
// Ports: CLK/CLR clock and async reset; START/TX_DATA/ABORT host request;
// BUSY/DONE/ERR/RX_DATA host status; CS_N/BIT_CLK SPI framing;
// S_*, R_*, DP_CLR strobes to the sender/receiver pair;
// S_EMPTY/R_FULL/R_DATA datapath status and data.
module spi_master_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       START,
  input  logic [7:0] TX_DATA,
  input  logic       ABORT,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] RX_DATA,
  output logic       CS_N,
  output logic       BIT_CLK,
  output logic [7:0] S_DATA,
  output logic       S_WRITE,
  output logic       S_TE,
  output logic       R_READ,
  output logic       R_RE,
  output logic       DP_CLR,
  input  logic       S_EMPTY,
  input  logic       R_FULL,
  input  logic [7:0] R_DATA
);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, SHIFT, CAPTURE, HOLD} state_t;

  // Half-period counter holds 0..CLK_DIV-1; setup/hold counter holds 0..max-1.
  localparam int HW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int SHW    = (SH_MAX > 1) ? $clog2(SH_MAX) : 1;

  localparam logic [HW-1:0]  DIV_LAST   = HW'(CLK_DIV - 1);
  localparam logic [SHW-1:0] SETUP_LAST = SHW'(CS_SETUP - 1);
  localparam logic [SHW-1:0] HOLD_LAST  = SHW'(CS_HOLD - 1);

  state_t         state;
  logic [HW-1:0]  hcnt;
  logic [3:0]     bit_cnt;   // rising BIT_CLK edges so far, 0..8
  logic [SHW-1:0] sh_cnt;
  logic           err_flag;
  logic           abort_q;   // one-cycle datapath clear after an abort

  assign DP_CLR = CLR | abort_q;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state    <= IDLE;
      hcnt     <= '0;
      bit_cnt  <= '0;
      sh_cnt   <= '0;
      err_flag <= 1'b0;
      abort_q  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      RX_DATA  <= 8'h00;
      CS_N     <= 1'b1;
      BIT_CLK  <= 1'b0;
      S_DATA   <= 8'h00;
      S_WRITE  <= 1'b0;
      S_TE     <= 1'b0;
      R_READ   <= 1'b0;
      R_RE     <= 1'b0;
    end else begin
      // Single-cycle pulses default low.
      S_WRITE <= 1'b0;
      R_READ  <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      abort_q <= 1'b0;

      if (ABORT) begin
        // Abort beats any START in the same cycle; in IDLE nothing happens.
        if (state != IDLE) begin
          state   <= IDLE;
          CS_N    <= 1'b1;
          BIT_CLK <= 1'b0;
          S_TE    <= 1'b0;
          R_RE    <= 1'b0;
          BUSY    <= 1'b0;
          abort_q <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (START) begin
              S_DATA  <= TX_DATA;
              BUSY    <= 1'b1;
              S_WRITE <= 1'b1;
              R_READ  <= 1'b1;   // zero the receiver count alongside the load
              state   <= LOAD;
            end
          end
          LOAD: begin
            CS_N   <= 1'b0;
            sh_cnt <= '0;
            state  <= SETUP;
          end
          SETUP: begin
            if (sh_cnt == SETUP_LAST) begin
              S_TE    <= 1'b1;
              R_RE    <= 1'b1;
              BIT_CLK <= 1'b0;
              hcnt    <= '0;
              bit_cnt <= '0;
              state   <= SHIFT;
            end else begin
              sh_cnt <= sh_cnt + SHW'(1);
            end
          end
          SHIFT: begin
            if (hcnt == DIV_LAST) begin
              hcnt    <= '0;
              BIT_CLK <= ~BIT_CLK;
              if (!BIT_CLK) begin
                bit_cnt <= bit_cnt + 4'd1;
              end else if (bit_cnt == 4'd8) begin
                // Falling edge after the eighth rise closes the shift window.
                S_TE   <= 1'b0;
                R_RE   <= 1'b0;
                R_READ <= 1'b1;
                state  <= CAPTURE;
              end
            end else begin
              hcnt <= hcnt + HW'(1);
            end
          end
          CAPTURE: begin
            RX_DATA  <= R_DATA;
            err_flag <= ~S_EMPTY | ~R_FULL;
            sh_cnt   <= '0;
            state    <= HOLD;
          end
          HOLD: begin
            if (sh_cnt == HOLD_LAST) begin
              CS_N  <= 1'b1;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              ERR   <= err_flag;
              state <= IDLE;
            end else begin
              sh_cnt <= sh_cnt + SHW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
